rtv_param_train_healer: RTL and testbench

- Parametrised successor to the two-train self-healing reservation block.
- Holds free-seat counters for NUM_TRAINS trains, with a live copy and a verified shadow copy.
- Runs each booking through a CHECK/COMMIT/VERIFY pipeline FSM and continuously scrubs live against shadow.
- Rolls back corrupted counters, predicts fault bursts with a sliding window, and enters a lockout mode when faults cluster.

---
 rtl/rtv_param_train_healer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_rtv_param_train_healer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rtv_param_train_healer.sv
// rtv_param_train_healer
//   Parametrised self-healing seat reservation block for NUM_TRAINS trains.
//   Each train has a live free-seat counter and a verified shadow copy.
//   Bookings run IDLE -> CHECK -> COMMIT -> VERIFY -> RESP. A mismatch seen
//   in VERIFY, or by the idle scrub of live against shadow, triggers HEAL.
//   A sliding window of recent faults drives predict_flag. A heal taken while
//   predict_flag is high restores every counter and starts a booking lockout.
//
//   Optional feature macro: SHADOW_PARITY_EN. When it is defined, each shadow
//   entry stores an even-parity bit. The idle scrub then also checks that bit.
//   A parity error resets both copies of the bad train to SEATS.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   book_req              booking request, held until accepted (busy low)
//   train_id/src/dest     target train and source/destination stations
//   num_tickets           tickets requested
//   inj_fault/inj_train   flip bit 0 of a live counter (fault injection)
//   busy                  request cannot be accepted this cycle
//   done                  one-cycle response strobe
//   success/booked_count/fare  response payload, held until the next done
//   seats_free            live counters, train 0 in the LSBs
//   fault_flag            one-cycle pulse per detected fault
//   predict_flag          fault count in the window >= PRED_THRESH
//   heal_trigger          high during the HEAL cycle
//   heal_mode             last heal mode (01 single, 10 all, 11 all + lockout)
module rtv_param_train_healer #(
    parameter int NUM_TRAINS  = 4,
    parameter int SEATS       = 10,
    parameter int FARE_RATE   = 20,
    parameter int FARE_W      = 12,
    parameter int FAULT_WIN   = 8,
    parameter int PRED_THRESH = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int TID_W      = $clog2(NUM_TRAINS),
    localparam int SEAT_W     = $clog2(SEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         book_req,
    input  logic [TID_W-1:0]             train_id,
    input  logic [2:0]                   src,
    input  logic [2:0]                   dest,
    input  logic [3:0]                   num_tickets,
    input  logic                         inj_fault,
    input  logic [TID_W-1:0]             inj_train,
    output logic                         busy,
    output logic                         done,
    output logic                         success,
    output logic [3:0]                   booked_count,
    output logic [FARE_W-1:0]            fare,
    output logic [NUM_TRAINS*SEAT_W-1:0] seats_free,
    output logic                         fault_flag,
    output logic                         predict_flag,
    output logic                         heal_trigger,
    output logic [1:0]                   heal_mode
);

    localparam int WC_W  = $clog2(FAULT_WIN + 1);
    localparam int LK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int CMP_W = (SEAT_W > 4) ? SEAT_W : 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_VERIFY = 3'd3;
    localparam logic [2:0] S_HEAL   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]                         state;
    logic [NUM_TRAINS-1:0][SEAT_W-1:0]  live, shadow, live_nx, shadow_nx;
    logic [TID_W-1:0]                   tid_r;
    logic [2:0]                         src_r, dest_r, hops;
    logic [3:0]                         nt_r;
    logic [FARE_W-1:0]                  fare_r;
    logic                               from_verify;
    logic [FAULT_WIN-1:0]               win;
    logic [WC_W-1:0]                    win_cnt;
    logic [LK_W-1:0]                    lock_cnt;
    logic                               mismatch, scrub_err, verify_ok, reject;
    logic                               tid_ok, inj_ok;
    logic [1:0]                         scrub_mode;

    // The comparisons are widened by one bit so that they stay meaningful
    // even when NUM_TRAINS is a power of two.
    assign tid_ok = ({1'b0, tid_r}     < (TID_W + 1)'(NUM_TRAINS));
    assign inj_ok = ({1'b0, inj_train} < (TID_W + 1)'(NUM_TRAINS));
    assign hops   = (dest_r >= src_r) ? (dest_r - src_r) : (src_r - dest_r);

    assign reject = (src_r == dest_r) || (nt_r == 4'd0) || !tid_ok ||
                    (CMP_W'(nt_r) > CMP_W'(live[tid_r])) || (lock_cnt != '0);

`ifdef SHADOW_PARITY_EN
    logic [NUM_TRAINS-1:0] shadow_par, par_nx, par_bad, par_bad_now;
    logic                  par_err;

    always_comb begin
        par_bad_now = '0;
        for (int i = 0; i < NUM_TRAINS; i++)
            par_bad_now[i] = shadow_par[i] ^ (^shadow[i]);
    end
    assign par_err   = |par_bad_now;
    assign scrub_err = mismatch | par_err;
`else
    assign scrub_err = mismatch;
`endif

    assign busy       = (state != S_IDLE) || scrub_err;
    assign seats_free = live;

    // A parity fault or a predicted burst turns a scrub heal into a full
    // restore with lockout.
`ifdef SHADOW_PARITY_EN
    assign scrub_mode = (predict_flag || par_err) ? 2'b11 : 2'b10;
`else
    assign scrub_mode = predict_flag ? 2'b11 : 2'b10;
`endif

    always_comb begin
        mismatch  = 1'b0;
        verify_ok = 1'b1;
        win_cnt   = '0;
        for (int i = 0; i < NUM_TRAINS; i++) begin
            if (live[i] != shadow[i])
                mismatch = 1'b1;
            if (TID_W'(i) == tid_r) begin
                if (live[i] != shadow[i] - SEAT_W'(nt_r))
                    verify_ok = 1'b0;
            end else if (live[i] != shadow[i]) begin
                verify_ok = 1'b0;
            end
        end
        for (int i = 0; i < FAULT_WIN; i++)
            win_cnt = win_cnt + WC_W'(win[i]);
    end

    // Next-state counters. Injection is applied last, on top of any
    // commit or heal write from the same edge.
    always_comb begin
        live_nx   = live;
        shadow_nx = shadow;
`ifdef SHADOW_PARITY_EN
        par_nx    = shadow_par;
`endif
        if (state == S_COMMIT)
            live_nx[tid_r] = live[tid_r] - SEAT_W'(nt_r);
        if (state == S_VERIFY && verify_ok) begin
            shadow_nx[tid_r] = live[tid_r];
`ifdef SHADOW_PARITY_EN
            par_nx[tid_r]    = ^live[tid_r];
`endif
        end
        if (state == S_HEAL) begin
            if (heal_mode == 2'b01)
                live_nx[tid_r] = shadow[tid_r];
            else
                live_nx = shadow;
`ifdef SHADOW_PARITY_EN
            for (int i = 0; i < NUM_TRAINS; i++) begin
                if (par_bad[i]) begin
                    live_nx[i]   = SEAT_W'(SEATS);
                    shadow_nx[i] = SEAT_W'(SEATS);
                    par_nx[i]    = ^(SEAT_W'(SEATS));
                end
            end
`endif
        end
        if (inj_fault && inj_ok)
            live_nx[inj_train][0] = ~live_nx[inj_train][0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            live         <= {NUM_TRAINS{SEAT_W'(SEATS)}};
            shadow       <= {NUM_TRAINS{SEAT_W'(SEATS)}};
            tid_r        <= '0;
            src_r        <= '0;
            dest_r       <= '0;
            nt_r         <= '0;
            fare_r       <= '0;
            from_verify  <= 1'b0;
            win          <= '0;
            lock_cnt     <= '0;
            done         <= 1'b0;
            success      <= 1'b0;
            booked_count <= '0;
            fare         <= '0;
            fault_flag   <= 1'b0;
            predict_flag <= 1'b0;
            heal_trigger <= 1'b0;
            heal_mode    <= 2'b00;
        end else begin
            live         <= live_nx;
            shadow       <= shadow_nx;
            win          <= {win[FAULT_WIN-2:0], fault_flag};
            predict_flag <= (int'(win_cnt) >= PRED_THRESH);
            done         <= 1'b0;
            fault_flag   <= 1'b0;
            heal_trigger <= 1'b0;
            if (lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;

            case (state)
                S_IDLE: begin
                    // The scrub wins over a request presented in the same cycle.
                    if (scrub_err) begin
                        state        <= S_HEAL;
                        fault_flag   <= 1'b1;
                        heal_trigger <= 1'b1;
                        from_verify  <= 1'b0;
                        heal_mode    <= scrub_mode;
                    end else if (book_req) begin
                        state  <= S_CHECK;
                        tid_r  <= train_id;
                        src_r  <= src;
                        dest_r <= dest;
                        nt_r   <= num_tickets;
                    end
                end
                S_CHECK: begin
                    if (reject) begin
                        state        <= S_RESP;
                        done         <= 1'b1;
                        success      <= 1'b0;
                        booked_count <= '0;
                        fare         <= '0;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    fare_r <= FARE_W'(int'(hops) * int'(nt_r) * FARE_RATE);
                    state  <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (verify_ok) begin
                        state        <= S_RESP;
                        done         <= 1'b1;
                        success      <= 1'b1;
                        booked_count <= nt_r;
                        fare         <= fare_r;
                    end else begin
                        state        <= S_HEAL;
                        fault_flag   <= 1'b1;
                        heal_trigger <= 1'b1;
                        from_verify  <= 1'b1;
                        heal_mode    <= predict_flag ? 2'b11 : 2'b01;
                    end
                end
                S_HEAL: begin
                    if (heal_mode == 2'b11)
                        lock_cnt <= LK_W'(LOCK_CYCLES);
                    if (from_verify) begin
                        state        <= S_RESP;
                        done         <= 1'b1;
                        success      <= 1'b0;
                        booked_count <= '0;
                        fare         <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SHADOW_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_par <= {NUM_TRAINS{^(SEAT_W'(SEATS))}};
            par_bad    <= '0;
        end else begin
            shadow_par <= par_nx;
            if (state == S_IDLE && scrub_err)
                par_bad <= par_bad_now;
            else if (state == S_HEAL)
                par_bad <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_rtv_param_train_healer.sv
// Directed testbench for rtv_param_train_healer with the default parameters
// (4 trains, 10 seats, FARE_RATE 20). Expected values are hand-computed.
module tb_rtv_param_train_healer;

    logic        clk = 1'b0;
    logic        rst, book_req, inj_fault;
    logic [1:0]  train_id, inj_train;
    logic [2:0]  src, dest;
    logic [3:0]  num_tickets;
    logic        busy, done, success, fault_flag, predict_flag, heal_trigger;
    logic [3:0]  booked_count;
    logic [11:0] fare;
    logic [15:0] seats_free;
    logic [1:0]  heal_mode;

    int errors = 0;
    int checks = 0;
    int lat;
    int nd;

    always #5 clk = ~clk;

    rtv_param_train_healer dut (
        .clk(clk), .rst(rst), .book_req(book_req), .train_id(train_id),
        .src(src), .dest(dest), .num_tickets(num_tickets),
        .inj_fault(inj_fault), .inj_train(inj_train),
        .busy(busy), .done(done), .success(success),
        .booked_count(booked_count), .fare(fare), .seats_free(seats_free),
        .fault_flag(fault_flag), .predict_flag(predict_flag),
        .heal_trigger(heal_trigger), .heal_mode(heal_mode)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge. The caller makes sure that busy is low.
    task automatic book(input logic [1:0] t, input logic [2:0] s, input logic [2:0] d,
                        input logic [3:0] n);
        book_req = 1'b1; train_id = t; src = s; dest = d; num_tickets = n;
        step();
        book_req = 1'b0;
    endtask

    // Number of edges from acceptance to done, or -1 if done never comes.
    task automatic wait_done(output int l);
        l = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; book_req = 1'b0; inj_fault = 1'b0;
        train_id = '0; inj_train = '0; src = '0; dest = '0; num_tickets = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_seats",   seats_free, 32'hAAAA);
        chk("rst_done",    done, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_mode",    heal_mode, 0);
        chk("rst_predict", predict_flag, 0);

        // Train 2, stations 1->4, 3 tickets: fare 3*3*20 = 180
        book(2'd2, 3'd1, 3'd4, 4'd3);
        chk("acc_busy", busy, 1);
        wait_done(lat);
        chk("ok_lat",     lat, 3);
        chk("ok_success", success, 1);
        chk("ok_count",   booked_count, 3);
        chk("ok_fare",    fare, 180);
        chk("ok_seats",   seats_free, 32'hA7AA);
        step();
        chk("done_pulse", done, 0);
        chk("hold_fare",  fare, 180);

        // Train 3, stations 5->0, 4 tickets: fare 5*4*20 = 400
        book(2'd3, 3'd5, 3'd0, 4'd4);
        wait_done(lat);
        chk("ok2_lat",  lat, 3);
        chk("ok2_fare", fare, 400);
        chk("ok2_seats", seats_free, 32'h67AA);
        step();

        // Rejected requests: too many tickets, src == dest, zero tickets
        book(2'd0, 3'd0, 3'd2, 4'd11);
        wait_done(lat);
        chk("rej11_lat",  lat, 1);
        chk("rej11_succ", success, 0);
        chk("rej11_fare", fare, 0);
        step();
        book(2'd1, 3'd3, 3'd3, 4'd2);
        wait_done(lat);
        chk("rejsd_lat",   lat, 1);
        chk("rejsd_count", booked_count, 0);
        step();
        book(2'd1, 3'd0, 3'd3, 4'd0);
        wait_done(lat);
        chk("rej0_lat", lat, 1);
        chk("rej_seats", seats_free, 32'h67AA);
        step();

        // Scrub heal after an idle injection on train 1
        inj_fault = 1'b1; inj_train = 2'd1;
        step();
        inj_fault = 1'b0;
        chk("scr_corrupt", seats_free[7:4], 11);
        chk("scr_busy1",   busy, 1);
        step();
        chk("scr_fault",   fault_flag, 1);
        chk("scr_trig",    heal_trigger, 1);
        chk("scr_mode",    heal_mode, 2'b10);
        chk("scr_busy2",   busy, 1);
        step();
        chk("scr_busy3",   busy, 0);
        chk("scr_seats",   seats_free, 32'h67AA);
        chk("scr_nodone",  done, 0);

        // Injection on the COMMIT edge of a booking for train 0
        book(2'd0, 3'd0, 3'd1, 4'd2);
        step();
        inj_fault = 1'b1; inj_train = 2'd0;
        step();
        inj_fault = 1'b0;
        step();
        chk("vf_fault", fault_flag, 1);
        chk("vf_mode",  heal_mode, 2'b01);
        chk("vf_trig",  heal_trigger, 1);
        step();
        chk("vf_done",  done, 1);
        chk("vf_succ",  success, 0);
        chk("vf_fare",  fare, 0);
        chk("vf_seats", seats_free, 32'h67AA);

        // Let the fault window drain
        for (int i = 0; i < 12; i++) step();
        chk("win_clear", predict_flag, 0);

        // Inject on train 3 at edges X, X+3 and X+6. Each heal stays in mode 10.
        for (int k = 0; k < 3; k++) begin
            inj_fault = 1'b1; inj_train = 2'd3;
            step();
            inj_fault = 1'b0;
            step();
            chk("burst_mode", heal_mode, 2'b10);
            step();
        end
        // Fourth injection at X+9: the window now holds three faults.
        inj_fault = 1'b1; inj_train = 2'd3;
        step();
        inj_fault = 1'b0;
        chk("predict", predict_flag, 1);
        step();
        chk("mode11",  heal_mode, 2'b11);
        chk("m11_trig", heal_trigger, 1);
        step();
        chk("m11_seats", seats_free, 32'h67AA);
        chk("m11_busy",  busy, 0);

        // A request during the lockout is rejected
        book(2'd1, 3'd0, 3'd2, 4'd1);
        wait_done(lat);
        chk("lock_lat",  lat, 1);
        chk("lock_succ", success, 0);
        for (int i = 0; i < 20; i++) step();
        // After the lockout: fare 2*1*20 = 40
        book(2'd1, 3'd0, 3'd2, 4'd1);
        wait_done(lat);
        chk("unlock_lat",  lat, 3);
        chk("unlock_succ", success, 1);
        chk("unlock_fare", fare, 40);
        chk("unlock_seats", seats_free, 32'h679A);
        step();

        // Reset in the middle of VERIFY
        book(2'd2, 3'd0, 3'd1, 4'd2);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mr_seats", seats_free, 32'hAAAA);
        chk("mr_done",  done, 0);
        chk("mr_succ",  success, 0);
        chk("mr_fare",  fare, 0);
        chk("mr_count", booked_count, 0);
        chk("mr_mode",  heal_mode, 0);
        chk("mr_pred",  predict_flag, 0);
        step(); step();
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) nd++;
        end
        chk("mr_nodone", nd, 0);
        chk("mr_seats2", seats_free, 32'hAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
